// File: rtl/pe_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Package     : pe_pkg                                                    |
// | Description : Shared state encodings and widths for the PE datapath.    |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
package pe_pkg;

  // Counter width for the default group size; modules with a different
  // COUNT derive their own width through cnt_width().
  localparam int DEF_COUNT = 4;
  localparam int CNT_W     = $clog2(DEF_COUNT + 1);

  typedef enum logic [0:0] {
    L_IDLE     = 1'b0,
    L_WAIT_LOW = 1'b1
  } l_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_REL  = 2'd2
  } r_state_t;

  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs_sync.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module      : hs_sync                                                   |
// | Description : STAGES-deep flop synchronizer for one handshake wire,     |
// |               synchronously cleared to 0.                               |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module      : psum_accumulator                                          |
// | Description : Sums COUNT words from a 4-phase input channel and emits   |
// |               each sum on a 4-phase output channel; both handshakes     |
// |               are synchronized into clk.                                |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module psum_accumulator
  import pe_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT       = 4,
  parameter int ACC_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         l_req,
  input  logic [WIDTH-1:0]             l_data,
  output logic                         l_ack,
  output logic                         r_req,
  output logic [ACC_WIDTH-1:0]         r_data,
  input  logic                         r_ack,
  output logic [$clog2(COUNT+1)-1:0]   grp_cnt
);

  localparam int               GRP_W    = cnt_width(COUNT);
  localparam logic [GRP_W-1:0] LAST_IDX = GRP_W'(COUNT - 1);

  logic req_s;
  logic ack_s;

  hs_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (l_req),
    .sync_o  (req_s)
  );

  hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (r_ack),
    .sync_o  (ack_s)
  );

  l_state_t             l_state_q;
  r_state_t             r_state_q;
  logic                 l_ack_q;
  logic                 r_req_q;
  logic [ACC_WIDTH-1:0] acc_q,       acc_d;
  logic [ACC_WIDTH-1:0] hold_q,      hold_d;
  logic [GRP_W-1:0]     cnt_q,       cnt_d;
  logic                 hold_full_q, hold_full_d;

  logic [ACC_WIDTH-1:0] sum;
  logic                 last_word;
  logic                 accept;
  logic                 hold_clr;

  assign sum       = acc_q + ACC_WIDTH'(l_data);
  assign last_word = (cnt_q == LAST_IDX);
  // The final word of a group needs an empty hold register; hold_full is
  // the registered flag, so a release on this edge is seen next cycle.
  assign accept    = (l_state_q == L_IDLE) && req_s && (!last_word || !hold_full_q);
  assign hold_clr  = (r_state_q == R_REL) && !ack_s;

  // Next-state for the accumulator, group counter and hold register.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (hold_clr) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      if (last_word) begin
        hold_d      = sum;
        hold_full_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + GRP_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Input channel FSM: ack on accept, release once the request drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_state_q <= L_IDLE;
      l_ack_q   <= 1'b0;
    end else begin
      unique case (l_state_q)
        L_IDLE: begin
          if (accept) begin
            l_ack_q   <= 1'b1;
            l_state_q <= L_WAIT_LOW;
          end
        end
        L_WAIT_LOW: begin
          if (!req_s) begin
            l_ack_q   <= 1'b0;
            l_state_q <= L_IDLE;
          end
        end
        default: begin
          l_ack_q   <= 1'b0;
          l_state_q <= L_IDLE;
        end
      endcase
    end
  end

  // Output channel FSM: offer the held sum, free the hold after ack falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_req_q   <= 1'b0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (hold_full_q) begin
            r_req_q   <= 1'b1;
            r_state_q <= R_REQ;
          end
        end
        R_REQ: begin
          if (ack_s) begin
            r_req_q   <= 1'b0;
            r_state_q <= R_REL;
          end
        end
        R_REL: begin
          if (!ack_s) begin
            r_state_q <= R_IDLE;
          end
        end
        default: begin
          r_req_q   <= 1'b0;
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign l_ack   = l_ack_q;
  assign r_req   = r_req_q;
  assign r_data  = hold_q;
  assign grp_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module      : tb_psum_accumulator                                       |
// | Description : Directed and random handshake bench for psum_accumulator; |
// |               a second 9-bit-sum instance shares all stimulus.          |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_psum_accumulator;

  localparam int TO = 200;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        l_req = 1'b0;
  logic [7:0]  l_data = '0;
  logic        r_ack = 1'b0;

  logic        l_ack,  r_req,  l_ack9, r_req9;
  logic [15:0] r_data;
  logic [8:0]  r_data9;
  logic [2:0]  grp_cnt, grp_cnt9;

  always #5 clk = ~clk;

  psum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(16), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .l_req(l_req), .l_data(l_data), .l_ack(l_ack),
    .r_req(r_req), .r_data(r_data), .r_ack(r_ack), .grp_cnt(grp_cnt)
  );

  psum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(9), .SYNC_STAGES(2)) u_dut9 (
    .clk(clk), .rst(rst), .l_req(l_req), .l_data(l_data), .l_ack(l_ack9),
    .r_req(r_req9), .r_data(r_data9), .r_ack(r_ack), .grp_cnt(grp_cnt9)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned got_q[$];
  int unsigned got9_q[$];
  bit          ack_hold  = 1'b0;
  bit          rand_mode = 1'b0;
  int          dly_cnt   = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned take();
    if (got_q.size() > 0) return got_q.pop_front();
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int unsigned take9();
    if (got9_q.size() > 0) return got9_q.pop_front();
    return 32'hFFFF_FFFF;
  endfunction

  // Output-channel neighbour: records each offered sum and acks it.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && r_req && !r_ack && !ack_hold) begin
        if (dly_cnt > 0) begin
          dly_cnt--;
        end else begin
          got_q.push_back(r_data);
          got9_q.push_back(r_data9);
          r_ack   = 1'b1;
          dly_cnt = rand_mode ? int'($urandom_range(0, 6)) : 0;
        end
      end else if (!r_req && r_ack) begin
        r_ack = 1'b0;
      end
    end
  end

  // One full 4-phase input transfer; reports rise and fall latencies.
  task automatic send_word(input logic [7:0] d, output int lat_r, output int lat_f);
    int n;
    @(posedge clk); #1;
    l_data = d;
    l_req  = 1'b1;
    n = 0;
    while (!l_ack && n < TO) begin
      @(posedge clk); #1;
      n++;
    end
    lat_r = n;
    check_eq("l_ack_rise", l_ack, 1);
    l_req = 1'b0;
    n = 0;
    while (l_ack && n < TO) begin
      @(posedge clk); #1;
      n++;
    end
    lat_f = n;
    check_eq("l_ack_fall", l_ack, 0);
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check_eq("result_count", got_q.size(), n);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lr, lf, toggles, n;
    bit          seen;
    int unsigned sum, exp_q[$], exp9_q[$];
    logic [7:0]  d;

    // Reset and idle.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_l_ack", l_ack, 0);
    check_eq("rst_r_req", r_req, 0);
    check_eq("rst_r_data", r_data, 0);
    check_eq("rst_grp_cnt", grp_cnt, 0);
    rst = 1'b0;
    toggles = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (l_ack !== 1'b0 || r_req !== 1'b0) toggles++;
    end
    check_eq("idle_toggles", toggles, 0);
    check_eq("idle_r_data", r_data, 0);
    check_eq("idle_grp_cnt", grp_cnt, 0);

    // 10+20+30+40 with immediate output ack.
    for (int i = 0; i < 4; i++) begin
      send_word(8'((i + 1) * 10), lr, lf);
      check_eq($sformatf("lat_rise_%0d", i), lr, 3);
      check_eq($sformatf("lat_fall_%0d", i), lf, 3);
      check_eq($sformatf("grp_cnt_%0d", i), grp_cnt, (i + 1) % 4);
    end
    wait_results(1);
    check_eq("sum_10_40", take(), 100);
    void'(take9());

    // 255 x 4: 1020 at 16 bits, wraps to 508 at 9 bits.
    repeat (20) @(posedge clk);
    got_q.delete();
    got9_q.delete();
    for (int i = 0; i < 4; i++) send_word(8'd255, lr, lf);
    wait_results(1);
    check_eq("sum_255x4", take(), 1020);
    check_eq("sum_255x4_w9", take9(), 508);

    // Back-pressure: output ack held off while a second group streams in.
    repeat (20) @(posedge clk);
    got_q.delete();
    got9_q.delete();
    ack_hold = 1'b1;
    for (int i = 0; i < 4; i++) send_word(8'd1, lr, lf);
    n = 0;
    while (!r_req && n < TO) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("bp_r_req", r_req, 1);
    for (int i = 0; i < 3; i++) begin
      send_word(8'd1, lr, lf);
      check_eq($sformatf("bp_lat_%0d", i + 5), lr, 3);
    end
    check_eq("bp_grp_cnt", grp_cnt, 3);
    @(posedge clk); #1;
    l_data = 8'd1;
    l_req  = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (l_ack) seen = 1'b1;
    end
    check_eq("bp_word8_stalled", seen, 0);
    check_eq("bp_grp_cnt_hold", grp_cnt, 3);
    check_eq("bp_r_data_stable", r_data, 4);
    ack_hold = 1'b0;
    n = 0;
    while (!l_ack && n < TO) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("bp_word8_ack", l_ack, 1);
    l_req = 1'b0;
    n = 0;
    while (l_ack && n < TO) begin
      @(posedge clk); #1;
      n++;
    end
    wait_results(2);
    check_eq("bp_first", take(), 4);
    check_eq("bp_second", take(), 4);
    got9_q.delete();

    // Reset in the middle of a group.
    repeat (20) @(posedge clk);
    got_q.delete();
    send_word(8'd7, lr, lf);
    @(posedge clk); #1;
    l_data = 8'd9;
    l_req  = 1'b1;
    n = 0;
    while (!l_ack && n < TO) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("mid_l_ack", l_ack, 1);
    check_eq("mid_grp_cnt", grp_cnt, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_l_ack", l_ack, 0);
    check_eq("mid_rst_r_req", r_req, 0);
    check_eq("mid_rst_r_data", r_data, 0);
    check_eq("mid_rst_grp_cnt", grp_cnt, 0);
    l_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    got9_q.delete();
    for (int i = 1; i <= 4; i++) send_word(8'(i), lr, lf);
    wait_results(1);
    check_eq("post_rst_sum", take(), 10);

    // Random traffic on both channels against a group-sum model.
    repeat (20) @(posedge clk);
    got_q.delete();
    got9_q.delete();
    rand_mode = 1'b1;
    sum = 0;
    for (int w = 0; w < 1000; w++) begin
      d = 8'($urandom_range(0, 255));
      sum += d;
      if (w % 4 == 3) begin
        exp_q.push_back(sum & 32'hFFFF);
        exp9_q.push_back(sum & 32'h1FF);
        sum = 0;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_word(d, lr, lf);
    end
    wait_results(250);
    for (int i = 0; i < 250; i++) begin
      check_eq($sformatf("rand_sum_%0d", i), take(), exp_q[i]);
      check_eq($sformatf("rand_sum9_%0d", i), take9(), exp9_q[i]);
    end
    check_eq("rand_grp_cnt", grp_cnt, 0);
    rand_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
